pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Stall/flush sequencer for the 5-stage pipeline. Sits beside the operand-forwarding mux and covers the hazards forwarding cannot resolve.
- Load-use: inserts a one-cycle bubble.
- Multi-cycle MUL in stage 3: holds the front end until the result is ready.
- Taken branch resolved in stage 3: flushes the younger instructions.
- Drives the PC enable, the p1-2 / p2-3 register enables, and the bubble/flush controls.

Parameters:
REG_ADDR_WIDTH, 4, register address width
CTRL_WIDTH, 6, width of the ctrl opcode field
NOP_CODE, 0, ctrl value of a NOP/bubble
LW_CODE, 6'h10, ctrl value of a load
MUL_CODE, 6'h08, ctrl value of a multiply
MUL_LATENCY, 4, cycles a MUL occupies stage 3 (>=1)
FLUSH_CYCLES, 1, cycles flush_p12 stays asserted after a taken branch (>=1)

Ports:
clk  in  1  clock, all state on rising edge
RST  in  1  asynchronous, active-low reset
ctrl_p12  in  CTRL_WIDTH  ctrl of instruction in decode (p1-2)
A_addr  in  REG_ADDR_WIDTH  source A of the decoding instruction
B_addr  in  REG_ADDR_WIDTH  source B of the decoding instruction
ctrl_p23  in  CTRL_WIDTH  ctrl of instruction entering execute (p2-3)
reg_addr_p23  in  REG_ADDR_WIDTH  destination of the p2-3 instruction
branch_taken  in  1  stage-3 branch/jump resolved taken this cycle
pc_en  out  1  PC update enable
en_p12  out  1  p1-2 register load enable
en_p23  out  1  p2-3 register load enable
bubble_p23  out  1  load NOP into p2-3 instead of decode output
flush_p12  out  1  load NOP into p1-2
busy  out  1  controller in a non-RUN state

Behaviour:
- States: RUN, LDSTALL, MULWAIT, FLUSH. An internal counter `cnt` is sized to hold max(MUL_LATENCY, FLUSH_CYCLES).
- Outputs are combinational from the current state and current inputs, so a hazard stalls in the same cycle it is detected.
- Default outputs: pc_en=1, en_p12=1, en_p23=1, bubble_p23=0, flush_p12=0, busy=(state!=RUN).
- While RST=0: state=RUN, cnt=0, all outputs at their defaults (busy=0).
- RUN checks three conditions in priority order: branch > mul > load-use.
  - Branch: branch_taken=1 → flush_p12=1, bubble_p23=1, pc_en=1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Mul: ctrl_p23==MUL_CODE and MUL_LATENCY>1 → pc_en=0, en_p12=0, en_p23=0. Go to MULWAIT with cnt=MUL_LATENCY-1. MUL_LATENCY==1 means no action.
  - Load-use: ctrl_p23==LW_CODE, ctrl_p12!=NOP_CODE, and (A_addr==reg_addr_p23 or B_addr==reg_addr_p23) → pc_en=0, en_p12=0, bubble_p23=1 (en_p23=1). Go to LDSTALL. Address 0 is compared like any other address.
- LDSTALL:
  - Defaults for one cycle; hazard detection suppressed.
  - Next state RUN.
  - branch_taken is honoured exactly as in RUN.
- MULWAIT:
  - cnt>1: hold (pc_en=0, en_p12=0, en_p23=0), cnt decrements.
  - cnt==1: release (defaults), next state RUN. This is the cycle the MUL leaves p2-3.
  - The MUL is in stage 3 for exactly MUL_LATENCY cycles, with MUL_LATENCY-1 held cycles.
  - branch_taken and load-use are ignored in MULWAIT.
- FLUSH:
  - flush_p12=1; cnt decrements; return to RUN when cnt reaches 1.
  - Load-use detection suppressed; a new branch_taken reloads cnt=FLUSH_CYCLES-1.
- Reset asserted mid-stall: immediate return to RUN and default outputs, asynchronously. No pending stall survives reset.
- Simultaneous load-use on both A and B: a single bubble only.

Optional Feature:
- Macro: PIPELINE_HAZARD_STATS_EN.
- Defined: adds output `stall_count` [15:0] and output `flush_count` [15:0].
  - stall_count increments every cycle pc_en==0; flush_count increments on each taken-branch detection.
  - Both saturate at 16'hFFFF and reset to 0 on RST=0.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Test Plan:
- Load-use: ctrl_p23=LW_CODE, reg_addr_p23=3, ctrl_p12=ADD with A_addr=3 → pc_en=0, en_p12=0, bubble_p23=1 for exactly 1 cycle; next cycle all defaults with busy=1 (LDSTALL), then busy=0.
- No false stall: same as load-use but ctrl_p12=NOP_CODE, or A_addr=5/B_addr=6 → defaults, busy stays 0.
- MUL, MUL_LATENCY=4: ctrl_p23=MUL_CODE → pc_en=0 and en_p23=0 for 3 consecutive cycles, pc_en=1 on the 4th, then RUN.
- Branch: branch_taken=1 in RUN → flush_p12=1, bubble_p23=1, pc_en=1 same cycle. With FLUSH_CYCLES=3, flush_p12 stays high for 3 cycles total.
- Branch and load-use together: LW hazard plus branch_taken=1 in the same cycle → flush behaviour only, pc_en=1, no LDSTALL entry.
- Reset mid-MUL: RST driven 0 in the 2nd MULWAIT cycle → outputs default immediately. After release, a new MUL restarts the full 3-cycle hold.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Handles the hazards operand forwarding cannot cover: a load-use bubble,
// a front-end hold while a multi-cycle MUL sits in stage 3, and a flush of
// younger instructions after a taken branch resolved in stage 3.
// Outputs are combinational from the current state and inputs, so a hazard
// stalls the pipeline in the same cycle it is detected.
// Optional build macro: PIPELINE_HAZARD_STATS_EN adds saturating
// stall_count / flush_count outputs.
module pipeline_hazard_ctrl #(
  parameter int                    REG_ADDR_WIDTH = 4,
  parameter int                    CTRL_WIDTH     = 6,
  parameter logic [CTRL_WIDTH-1:0] NOP_CODE       = '0,
  parameter logic [CTRL_WIDTH-1:0] LW_CODE        = CTRL_WIDTH'('h10),
  parameter logic [CTRL_WIDTH-1:0] MUL_CODE       = CTRL_WIDTH'('h08),
  parameter int                    MUL_LATENCY    = 4,
  parameter int                    FLUSH_CYCLES   = 1
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic [CTRL_WIDTH-1:0]     ctrl_p12,
  input  logic [REG_ADDR_WIDTH-1:0] A_addr,
  input  logic [REG_ADDR_WIDTH-1:0] B_addr,
  input  logic [CTRL_WIDTH-1:0]     ctrl_p23,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr_p23,
  input  logic                      branch_taken,
  output logic                      pc_en,
  output logic                      en_p12,
  output logic                      en_p23,
  output logic                      bubble_p23,
  output logic                      flush_p12,
  output logic                      busy
`ifdef PIPELINE_HAZARD_STATS_EN
  ,
  output logic [15:0]               stall_count,
  output logic [15:0]               flush_count
`endif
);

  // Counter must hold the larger of the two reload values.
  localparam int CNT_MAX = (MUL_LATENCY > FLUSH_CYCLES) ? MUL_LATENCY : FLUSH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUL_RELOAD   = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LDSTALL = 2'd1;
  localparam logic [1:0] ST_MULWAIT = 2'd2;
  localparam logic [1:0] ST_FLUSH   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mul_hit;
  logic             lu_hit;

  // A MUL of latency 1 never needs a hold; a single bubble covers A, B or both.
  assign mul_hit = (ctrl_p23 == MUL_CODE) && (MUL_LATENCY > 1);
  assign lu_hit  = (ctrl_p23 == LW_CODE) && (ctrl_p12 != NOP_CODE) &&
                   ((A_addr == reg_addr_p23) || (B_addr == reg_addr_p23));

  // Next-state and output decode; reset forces every output to its default.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_en      = 1'b1;
    en_p12     = 1'b1;
    en_p23     = 1'b1;
    bubble_p23 = 1'b0;
    flush_p12  = 1'b0;
    busy       = (state_q != ST_RUN);

    case (state_q)
      ST_RUN, ST_LDSTALL: begin
        if (state_q == ST_LDSTALL) state_d = ST_RUN;
        if (branch_taken) begin
          flush_p12  = 1'b1;
          bubble_p23 = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else if (state_q == ST_RUN) begin
          // Hazard detection only runs in RUN; LDSTALL is the bubble's shadow cycle.
          if (mul_hit) begin
            pc_en   = 1'b0;
            en_p12  = 1'b0;
            en_p23  = 1'b0;
            state_d = ST_MULWAIT;
            cnt_d   = MUL_RELOAD;
          end else if (lu_hit) begin
            pc_en      = 1'b0;
            en_p12     = 1'b0;
            bubble_p23 = 1'b1;
            state_d    = ST_LDSTALL;
          end
        end
      end
      ST_MULWAIT: begin
        // Branches and load-use are ignored until the MUL leaves p2-3.
        if (cnt_q > CNT_ONE) begin
          pc_en  = 1'b0;
          en_p12 = 1'b0;
          en_p23 = 1'b0;
          cnt_d  = cnt_q - CNT_ONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin // ST_FLUSH
        flush_p12 = 1'b1;
        if (branch_taken) begin
          cnt_d = FLUSH_RELOAD;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    endcase

    if (!RST) begin
      pc_en      = 1'b1;
      en_p12     = 1'b1;
      en_p23     = 1'b1;
      bubble_p23 = 1'b0;
      flush_p12  = 1'b0;
      busy       = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPELINE_HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        flush_evt;

  // A taken branch is acted on everywhere except MULWAIT.
  assign flush_evt = branch_taken && (state_q != ST_MULWAIT);

  // Saturating event counters.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_evt && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MUL_LATENCY=4, FLUSH_CYCLES=3).
// Each step drives inputs just after a rising edge, pushes the expected
// output vector {pc_en,en_p12,en_p23,bubble_p23,flush_p12,busy}, and the
// owning test task pops and compares it on the falling edge.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] NOP = 6'h00;
  localparam logic [5:0] ADD = 6'h01;
  localparam logic [5:0] LW  = 6'h10;
  localparam logic [5:0] MUL = 6'h08;

  // Expected vectors: {pc_en, en_p12, en_p23, bubble_p23, flush_p12, busy}
  localparam logic [5:0] E_DEF = 6'b111000; // RUN, no hazard
  localparam logic [5:0] E_LD  = 6'b001100; // load-use bubble in RUN
  localparam logic [5:0] E_LDS = 6'b111001; // LDSTALL shadow cycle
  localparam logic [5:0] E_MH  = 6'b000000; // MUL detected in RUN
  localparam logic [5:0] E_MW  = 6'b000001; // MULWAIT hold
  localparam logic [5:0] E_MR  = 6'b111001; // MULWAIT release
  localparam logic [5:0] E_BR  = 6'b111110; // branch in RUN
  localparam logic [5:0] E_BRL = 6'b111111; // branch in LDSTALL
  localparam logic [5:0] E_FL  = 6'b111011; // FLUSH state

  typedef struct {
    bit         rst;
    logic [5:0] c12;
    logic [3:0] a;
    logic [3:0] b;
    logic [5:0] c23;
    logic [3:0] rd;
    bit         br;
    logic [5:0] exp;
  } step_t;

  logic       clk = 1'b0;
  logic       RST;
  logic [5:0] ctrl_p12, ctrl_p23;
  logic [3:0] A_addr, B_addr, reg_addr_p23;
  logic       branch_taken;
  logic       pc_en, en_p12, en_p23, bubble_p23, flush_p12, busy;
`ifdef PIPELINE_HAZARD_STATS_EN
  logic [15:0] stall_count, flush_count;
`endif

  logic [5:0] obs;
  logic [5:0] exp_q[$];
  int         n_cmp = 0;
  int         n_mis = 0;

  assign obs = {pc_en, en_p12, en_p23, bubble_p23, flush_p12, busy};

  pipeline_hazard_ctrl #(
    .REG_ADDR_WIDTH(4),
    .CTRL_WIDTH    (6),
    .NOP_CODE      (NOP),
    .LW_CODE       (LW),
    .MUL_CODE      (MUL),
    .MUL_LATENCY   (4),
    .FLUSH_CYCLES  (3)
  ) dut (
    .clk          (clk),
    .RST          (RST),
    .ctrl_p12     (ctrl_p12),
    .A_addr       (A_addr),
    .B_addr       (B_addr),
    .ctrl_p23     (ctrl_p23),
    .reg_addr_p23 (reg_addr_p23),
    .branch_taken (branch_taken),
    .pc_en        (pc_en),
    .en_p12       (en_p12),
    .en_p23       (en_p23),
    .bubble_p23   (bubble_p23),
    .flush_p12    (flush_p12),
    .busy         (busy)
`ifdef PIPELINE_HAZARD_STATS_EN
    ,
    .stall_count  (stall_count),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic step_t mk(bit rst, logic [5:0] c12, logic [3:0] a, logic [3:0] b,
                               logic [5:0] c23, logic [3:0] rd, bit br, logic [5:0] exp);
    step_t s;
    s.rst = rst; s.c12 = c12; s.a = a; s.b = b;
    s.c23 = c23; s.rd = rd; s.br = br; s.exp = exp;
    return s;
  endfunction

  // Apply one cycle of stimulus after the rising edge, record its expectation,
  // and return on the falling edge where outputs are sampled.
  task automatic drive(input step_t st);
    @(posedge clk);
    #1;
    RST          = st.rst;
    ctrl_p12     = st.c12;
    A_addr       = st.a;
    B_addr       = st.b;
    ctrl_p23     = st.c23;
    reg_addr_p23 = st.rd;
    branch_taken = st.br;
    exp_q.push_back(st.exp);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step_t s[$];
    logic [5:0] got, want;
    s.push_back(mk(0, ADD, 4'd3, 4'd0, LW,  4'd3, 0, E_DEF)); // hazard visible during reset
    s.push_back(mk(0, NOP, 4'd0, 4'd0, MUL, 4'd0, 1, E_DEF)); // branch + mul during reset
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_DEF)); // released, idle
    foreach (s[i]) begin
      drive(s[i]);
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL reset[%0d]: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    step_t s[$];
    logic [5:0] got, want;
    s.push_back(mk(1, ADD, 4'd3, 4'd9, LW,  4'd3, 0, E_LD));  // hazard on A
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_LDS));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_DEF));
    s.push_back(mk(1, ADD, 4'd1, 4'd7, LW,  4'd7, 0, E_LD));  // hazard on B
    s.push_back(mk(1, ADD, 4'd1, 4'd7, LW,  4'd7, 0, E_LDS)); // detection suppressed
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_DEF));
    s.push_back(mk(1, ADD, 4'd2, 4'd2, LW,  4'd2, 0, E_LD));  // A and B: one bubble
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_LDS));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_DEF));
    s.push_back(mk(1, ADD, 4'd0, 4'd5, LW,  4'd0, 0, E_LD));  // address 0 compared
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_LDS));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_DEF));
    foreach (s[i]) begin
      drive(s[i]);
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_no_false_stall();
    step_t s[$];
    logic [5:0] got, want;
    s.push_back(mk(1, NOP, 4'd3, 4'd3, LW,  4'd3, 0, E_DEF)); // decode is a NOP
    s.push_back(mk(1, ADD, 4'd5, 4'd6, LW,  4'd3, 0, E_DEF)); // no address match
    s.push_back(mk(1, ADD, 4'd3, 4'd3, ADD, 4'd3, 0, E_DEF)); // producer not a load
    s.push_back(mk(1, ADD, 4'd3, 4'd3, 6'h11, 4'd3, 0, E_DEF)); // near-miss opcode
    foreach (s[i]) begin
      drive(s[i]);
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL no_false_stall[%0d]: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_mul();
    step_t s[$];
    logic [5:0] got, want;
    s.push_back(mk(1, NOP, 4'd0, 4'd0, MUL, 4'd4, 0, E_MH));  // held cycle 1
    s.push_back(mk(1, NOP, 4'd0, 4'd0, MUL, 4'd4, 1, E_MW));  // held 2, branch ignored
    s.push_back(mk(1, ADD, 4'd4, 4'd0, LW,  4'd4, 0, E_MW));  // held 3, load-use ignored
    s.push_back(mk(1, NOP, 4'd0, 4'd0, MUL, 4'd4, 0, E_MR));  // 4th cycle: release
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_DEF));
    foreach (s[i]) begin
      drive(s[i]);
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL mul[%0d]: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_branch();
    step_t s[$];
    logic [5:0] got, want;
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 1, E_BR));  // flush cycle 1
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_FL));  // flush cycle 2
    s.push_back(mk(1, ADD, 4'd3, 4'd0, LW,  4'd3, 0, E_FL));  // cycle 3, load-use suppressed
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_DEF));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 1, E_BR));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_FL));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 1, E_FL));  // new branch reloads
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_FL));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_FL));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_DEF));
    foreach (s[i]) begin
      drive(s[i]);
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL branch[%0d]: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_branch_and_load();
    step_t s[$];
    logic [5:0] got, want;
    s.push_back(mk(1, ADD, 4'd3, 4'd0, LW,  4'd3, 1, E_BR));  // branch beats load-use
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_FL));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_FL));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_DEF));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, MUL, 4'd2, 1, E_BR));  // branch beats MUL
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_FL));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_FL));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_DEF));
    s.push_back(mk(1, ADD, 4'd8, 4'd6, LW,  4'd6, 0, E_LD));  // load-use first
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 1, E_BRL)); // branch in LDSTALL
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_FL));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_FL));
    s.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_DEF));
    foreach (s[i]) begin
      drive(s[i]);
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL branch_and_load[%0d]: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    step_t pre[$];
    step_t post[$];
    logic [5:0] got, want;
    pre.push_back(mk(1, NOP, 4'd0, 4'd0, MUL, 4'd1, 0, E_MH));
    pre.push_back(mk(1, NOP, 4'd0, 4'd0, MUL, 4'd1, 0, E_MW)); // 1st MULWAIT cycle
    pre.push_back(mk(1, NOP, 4'd0, 4'd0, MUL, 4'd1, 0, E_MW)); // 2nd MULWAIT cycle
    foreach (pre[i]) begin
      drive(pre[i]);
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL reset_mid_mul_pre[%0d]: got %b expected %b", i, got, want);
      end
    end
    // Assert reset inside the 2nd MULWAIT cycle, away from any clock edge.
    RST = 1'b0;
    exp_q.push_back(E_DEF);
    #1;
    got = obs; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL reset_mid_mul_async: got %b expected %b", got, want);
    end
    post.push_back(mk(0, NOP, 4'd0, 4'd0, MUL, 4'd1, 0, E_DEF)); // still in reset
    post.push_back(mk(1, NOP, 4'd0, 4'd0, MUL, 4'd1, 0, E_MH));  // fresh MUL
    post.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_MW));
    post.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_MW));
    post.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_MR));
    post.push_back(mk(1, NOP, 4'd0, 4'd0, NOP, 4'd0, 0, E_DEF));
    foreach (post[i]) begin
      drive(post[i]);
      got = obs; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_mis++;
        $display("FAIL reset_mid_mul_post[%0d]: got %b expected %b", i, got, want);
      end
    end
  endtask

  // Time limit: every wait above is a clock edge, so this only trips on a broken clock.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST          = 1'b0;
    ctrl_p12     = NOP;
    ctrl_p23     = NOP;
    A_addr       = '0;
    B_addr       = '0;
    reg_addr_p23 = '0;
    branch_taken = 1'b0;
    repeat (2) @(posedge clk);

    test_reset();
    test_load_use();
    test_no_false_stall();
    test_mul();
    test_branch();
    test_branch_and_load();
    test_reset_mid_mul();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
